sorting: RTL and testbench
==========================

# sorting

Packet-sorting buffer. It captures one packet of up to 2^AWIDTH unsigned words framed by sop/eop/val, sorts the packet in ascending order in place, then streams it out with the same framing. While it sorts and outputs, it ignores new input and raises busy_o. It sits inline on a val/sop/eop streaming path, and upstream must respect busy_o.

## Interface
- DWIDTH, 8: data word width, in bits.
- AWIDTH, 3: address width. Capacity is 2^AWIDTH words (8 by default).

- clk_i  in  1  single clock; everything is on the rising edge.
- srst_i  in  1  reset. Asynchronous, active-low (0 = reset).
- data_i  in  DWIDTH  input word.
- sop_i  in  1  first word of the packet (qualified by val_i).
- eop_i  in  1  last word of the packet (qualified by val_i).
- val_i  in  1  input word valid.
- data_o  out  DWIDTH  output word. Forced to 0 when val_o=0.
- sop_o  out  1  first (smallest) output word.
- eop_o  out  1  last (largest) output word.
- val_o  out  1  output word valid.
- busy_o  out  1  block is sorting or outputting; input is ignored.

## Operation
- Storage: register array mem[0..2^AWIDTH-1], each DWIDTH bits wide.
- Word count N: AWIDTH+1 bits wide, range 1..2^AWIDTH.
- States: IDLE, SORT, OUTPUT. busy_o = (state != IDLE).
- IDLE, receiving a packet:
  - val_i&sop_i writes data_i to mem[0] and sets wr_ptr=1. This restarts the packet even if one is already in progress.
  - val_i without sop_i while a packet is in progress writes mem[wr_ptr] and increments wr_ptr.
  - val_i while no packet is in progress is ignored. Cycles with val_i=0 inside a packet are gaps and are allowed.
  - Words beyond 2^AWIDTH are dropped; the count saturates at 2^AWIDTH.
  - val_i&eop_i writes its word (if space remains), latches N, and moves to SORT.
  - sop_i&eop_i on the same valid beat is a 1-word packet.
- SORT: odd-even transposition sort, exactly N cycles.
  - Phase p compare-exchanges pairs (i, i+1), where i ≡ p mod 2 and i+1 < N.
  - Comparison is unsigned; the smaller value goes to the lower index. Equal values are not swapped.
  - After phase N-1, move to OUTPUT with rd_ptr=0.
- OUTPUT: one word per cycle for N consecutive cycles, with no gaps.
  - val_o=1 and data_o=mem[rd_ptr].
  - sop_o = (rd_ptr==0), eop_o = (rd_ptr==N-1). Both are 1 when N=1.
  - After the eop beat, return to IDLE.
- While busy_o=1, all input strobes are ignored and no partial packet is retained.
- Reset (srst_i=0, asynchronous) takes effect immediately:
  - state=IDLE; N, wr_ptr and rd_ptr are cleared.
  - val_o=sop_o=eop_o=busy_o=0 and data_o=0.
  - mem is not cleared.
  - Reset mid-packet, mid-sort or mid-output aborts the packet; nothing further is output.

## Timing
- Let edge E0 be the edge that samples val_i&eop_i.
- Cycles 1..N after E0: SORT, busy_o=1, val_o=0.
- Cycles N+1..2N: OUTPUT. The sop beat is in cycle N+1 and the eop beat in cycle 2N.
- Cycle 2N+1: IDLE, busy_o=0. A new sop is accepted from this cycle on.
- Total latency from eop-in to eop-out is 2N cycles. busy_o is continuous from cycle 1 through cycle 2N.
- busy_o=0 while a packet is being received.
- All outputs come from registers (state, pointers, mem); there are no combinational paths from inputs to outputs.

## Test plan
- Reset: hold srst_i=0 for 2 cycles -> all outputs 0; release -> busy_o=0, val_o=0.
- Full packet 8 words {200,3,77,3,255,0,128,9} -> busy_o high in cycle 1 after eop. Output in cycles 9..16 is {0,3,3,9,77,128,200,255}; sop_o is only on 0, eop_o is only on 255, and busy_o=0 in cycle 17.
- Short packet 3 words {5,1,4} -> output {1,4,5} in cycles 4..6; busy_o falls in cycle 7.
- Back-to-back: start the next packet in the first cycle with busy_o=0; stimulus during busy_o=1 is ignored. Run 200 random packets of length 3..8 and check against a sorted reference model plus sop/eop/val framing.
- Edge cases:
  - 1-word packet (sop_i&eop_i together) -> a single beat with sop_o=eop_o=1, 2 cycles after input.
  - 10-word packet -> only the first 8 words are sorted and output.
  - val_i gaps inside a packet are tolerated.
- Abort: pull srst_i low during OUTPUT -> val_o and busy_o drop immediately; the next packet is sorted correctly.

Source files
------------

// File: rtl/sorting.sv
// Packet-sorting buffer: captures one sop/eop-framed packet of up to
// 2^AWIDTH unsigned words, sorts it in place with an odd-even transposition
// network (one phase per cycle, N phases), then streams it out in ascending
// order with the same framing. New input is ignored while busy_o is high.
module sorting #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              sop_i,
    input  logic              eop_i,
    input  logic              val_i,
    output logic [DWIDTH-1:0] data_o,
    output logic              sop_o,
    output logic              eop_o,
    output logic              val_o,
    output logic              busy_o
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SORT,
        S_OUTPUT
    } state_t;

    state_t            r_state;
    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AWIDTH:0]   r_wr_ptr;
    logic [AWIDTH:0]   r_cnt;
    logic [AWIDTH:0]   r_phase;
    logic [AWIDTH:0]   r_rd_ptr;
    logic              r_in_pkt;

    logic              w_idle;
    logic              w_accept_sop;
    logic              w_accept_cont;
    logic              w_room;
    logic              w_wr_en;
    logic [AWIDTH-1:0] w_wr_addr;
    logic [AWIDTH:0]   w_wr_ptr_inc;
    logic              w_last_phase;
    logic              w_last_beat;
    logic [DEPTH-2:0]  w_swap;
    logic [DWIDTH-1:0] w_sorted [DEPTH];

    // Input acceptance: sop always (re)starts a packet, other beats only
    // extend a packet already in progress. Nothing is accepted while busy.
    assign w_idle        = (r_state == S_IDLE);
    assign w_accept_sop  = w_idle && val_i && sop_i;
    assign w_accept_cont = w_idle && val_i && !sop_i && r_in_pkt;
    assign w_room        = (r_wr_ptr < DEPTH_C);
    // Writes are suppressed during reset so an aborted packet cannot
    // disturb the array contents while reset is held.
    assign w_wr_en       = srst_i && (w_accept_sop || (w_accept_cont && w_room));
    assign w_wr_addr     = sop_i ? '0 : r_wr_ptr[AWIDTH-1:0];
    // Word count saturates at capacity; excess words are dropped.
    assign w_wr_ptr_inc  = w_room ? (r_wr_ptr + 1'b1) : r_wr_ptr;

    assign w_last_phase  = (r_phase == (r_cnt - 1'b1));
    assign w_last_beat   = (r_rd_ptr == (r_cnt - 1'b1));

    // Compare-exchange decision for each adjacent pair (gi, gi+1): active
    // when the pair parity matches the phase parity and both slots are
    // inside the packet. Equal values are left in place.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH - 1; gi++) begin : g_pair
            localparam logic            PAIR_PARITY = 1'(gi % 2);
            localparam logic [AWIDTH:0] UPPER_IDX   = (AWIDTH + 1)'(gi + 1);
            assign w_swap[gi] = (r_phase[0] == PAIR_PARITY) &&
                                (UPPER_IDX < r_cnt) &&
                                (r_mem[gi] > r_mem[gi+1]);
        end
    endgenerate

    // Next value of each slot after the current phase. Active pairs are
    // disjoint, so a slot is touched by at most one exchange.
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            if (gi == 0) begin : g_first
                assign w_sorted[gi] = w_swap[gi] ? r_mem[gi+1] : r_mem[gi];
            end else if (gi == DEPTH - 1) begin : g_last
                assign w_sorted[gi] = w_swap[gi-1] ? r_mem[gi-1] : r_mem[gi];
            end else begin : g_mid
                assign w_sorted[gi] = w_swap[gi]   ? r_mem[gi+1] :
                                      w_swap[gi-1] ? r_mem[gi-1] : r_mem[gi];
            end
        end
    endgenerate

    // Packet storage: written by accepted input beats while idle, rewritten
    // by one transposition phase per cycle while sorting. Not reset.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= data_i;
        end else if (srst_i && (r_state == S_SORT)) begin
            for (int j = 0; j < DEPTH; j++) begin
                r_mem[j] <= w_sorted[j];
            end
        end
    end

    // Control FSM: receive -> sort for N cycles -> output N beats -> idle.
    always_ff @(posedge clk_i or negedge srst_i) begin
        if (!srst_i) begin
            r_state  <= S_IDLE;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            r_phase  <= '0;
            r_rd_ptr <= '0;
            r_in_pkt <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_sop) begin
                        r_wr_ptr <= (AWIDTH + 1)'(1);
                        if (eop_i) begin
                            r_cnt    <= (AWIDTH + 1)'(1);
                            r_in_pkt <= 1'b0;
                            r_phase  <= '0;
                            r_state  <= S_SORT;
                        end else begin
                            r_in_pkt <= 1'b1;
                        end
                    end else if (w_accept_cont) begin
                        r_wr_ptr <= w_wr_ptr_inc;
                        if (eop_i) begin
                            r_cnt    <= w_wr_ptr_inc;
                            r_in_pkt <= 1'b0;
                            r_phase  <= '0;
                            r_state  <= S_SORT;
                        end
                    end
                end
                S_SORT: begin
                    if (w_last_phase) begin
                        r_rd_ptr <= '0;
                        r_state  <= S_OUTPUT;
                    end else begin
                        r_phase <= r_phase + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (w_last_beat) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs are pure decodes of state, read pointer and storage.
    assign busy_o = (r_state != S_IDLE);
    assign val_o  = (r_state == S_OUTPUT);
    assign data_o = val_o ? r_mem[r_rd_ptr[AWIDTH-1:0]] : '0;
    assign sop_o  = val_o && (r_rd_ptr == '0);
    assign eop_o  = val_o && w_last_beat;

endmodule

// File: tb/tb_sorting.sv
// Self-checking bench for the packet-sorting buffer: directed cases plus
// random packets, each compared beat by beat against a sorted reference.
module tb_sorting;

    localparam int DW  = 8;
    localparam int CAP = 8;

    logic          clk_i;
    logic          srst_i;
    logic [DW-1:0] data_i;
    logic          sop_i;
    logic          eop_i;
    logic          val_i;
    logic [DW-1:0] data_o;
    logic          sop_o;
    logic          eop_o;
    logic          val_o;
    logic          busy_o;

    int errors = 0;
    int checks = 0;
    int pkt [16];
    int exp_q [$];

    sorting #(.DWIDTH(DW), .AWIDTH(3)) dut (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .data_i (data_i),
        .sop_i  (sop_i),
        .eop_i  (eop_i),
        .val_i  (val_i),
        .data_o (data_o),
        .sop_o  (sop_o),
        .eop_o  (eop_o),
        .val_o  (val_o),
        .busy_o (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic idle_inputs();
        val_i  = 1'b0;
        sop_i  = 1'b0;
        eop_i  = 1'b0;
        data_i = '0;
    endtask

    // Random strobes while busy; the design must ignore all of them.
    task automatic junk_inputs();
        val_i  = 1'($urandom_range(0, 1));
        sop_i  = 1'($urandom_range(0, 1));
        eop_i  = 1'($urandom_range(0, 1));
        data_i = DW'($urandom_range(0, 255));
    endtask

    task automatic drive_beat(input int d, input bit s, input bit e);
        val_i  = 1'b1;
        data_i = DW'(d);
        sop_i  = s;
        eop_i  = e;
        @(negedge clk_i);
    endtask

    // Reference: keep the first CAP words and emit them in ascending order
    // by repeatedly extracting the minimum.
    task automatic build_expected(input int n);
        int tmp [$];
        int m;
        int mi;
        m = (n > CAP) ? CAP : n;
        exp_q.delete();
        for (int i = 0; i < m; i++) tmp.push_back(pkt[i]);
        while (tmp.size() > 0) begin
            mi = 0;
            for (int i = 1; i < tmp.size(); i++) if (tmp[i] < tmp[mi]) mi = i;
            exp_q.push_back(tmp[mi]);
            tmp.delete(mi);
        end
    endtask

    task automatic send_pkt(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 2) == 0) begin
                val_i  = 1'b0;
                sop_i  = 1'b0;
                eop_i  = 1'b0;
                data_i = DW'($urandom_range(0, 255));
                @(negedge clk_i);
            end
            drive_beat(pkt[k], k == 0, k == n - 1);
        end
    endtask

    // Entered at the negedge of cycle 1 after the eop edge. Checks m sort
    // cycles, m output beats, then idle in cycle 2m+1 (left at that negedge).
    task automatic run_check(input string name, input int m);
        for (int c = 1; c <= m; c++) begin
            check($sformatf("%s sort c%0d busy", name, c), busy_o, 1);
            check($sformatf("%s sort c%0d val", name, c), val_o, 0);
            check($sformatf("%s sort c%0d data", name, c), data_o, 0);
            junk_inputs();
            @(negedge clk_i);
        end
        for (int k = 0; k < m; k++) begin
            check($sformatf("%s out%0d val", name, k), val_o, 1);
            check($sformatf("%s out%0d data", name, k), data_o, exp_q[k]);
            check($sformatf("%s out%0d sop", name, k), sop_o, (k == 0) ? 1 : 0);
            check($sformatf("%s out%0d eop", name, k), eop_o, (k == m - 1) ? 1 : 0);
            check($sformatf("%s out%0d busy", name, k), busy_o, 1);
            junk_inputs();
            @(negedge clk_i);
        end
        check($sformatf("%s end busy", name), busy_o, 0);
        check($sformatf("%s end val", name), val_o, 0);
        idle_inputs();
        $display("pkt %s len=%0d checked", name, m);
    endtask

    task automatic do_pkt(input string name, input int n, input bit gaps);
        build_expected(n);
        send_pkt(n, gaps);
        run_check(name, (n > CAP) ? CAP : n);
    endtask

    initial begin
        int n;
        idle_inputs();
        srst_i = 1'b0;

        // Reset held for two cycles
        repeat (2) @(negedge clk_i);
        check("rst val", val_o, 0);
        check("rst sop", sop_o, 0);
        check("rst eop", eop_o, 0);
        check("rst busy", busy_o, 0);
        check("rst data", data_o, 0);
        srst_i = 1'b1;
        @(negedge clk_i);
        check("rel busy", busy_o, 0);
        check("rel val", val_o, 0);

        // Full 8-word packet
        pkt[0] = 200; pkt[1] = 3; pkt[2] = 77; pkt[3] = 3;
        pkt[4] = 255; pkt[5] = 0; pkt[6] = 128; pkt[7] = 9;
        do_pkt("full8", 8, 1'b0);

        // Short 3-word packet, started in the first idle cycle
        pkt[0] = 5; pkt[1] = 1; pkt[2] = 4;
        do_pkt("short3", 3, 1'b0);

        // 1-word packet
        pkt[0] = 42;
        do_pkt("one", 1, 1'b0);

        // 10-word packet: only the first 8 words survive
        for (int i = 0; i < 10; i++) pkt[i] = (i < 8) ? (100 - i * 7) : 1;
        do_pkt("over10", 10, 1'b0);

        // Packet with gaps
        pkt[0] = 9; pkt[1] = 250; pkt[2] = 17; pkt[3] = 17; pkt[4] = 2;
        do_pkt("gaps5", 5, 1'b1);

        // Stray beats with no packet in progress are ignored
        drive_beat(77, 1'b0, 1'b0);
        drive_beat(78, 1'b0, 1'b1);
        idle_inputs();
        @(negedge clk_i);
        check("stray busy", busy_o, 0);
        check("stray val", val_o, 0);

        // A second sop restarts the packet
        drive_beat(50, 1'b1, 1'b0);
        drive_beat(60, 1'b0, 1'b0);
        drive_beat(7, 1'b1, 1'b0);
        drive_beat(2, 1'b0, 1'b0);
        drive_beat(1, 1'b0, 1'b1);
        exp_q = {1, 2, 7};
        run_check("restart", 3);

        // Reset abort during output
        pkt[0] = 30; pkt[1] = 10; pkt[2] = 20; pkt[3] = 50; pkt[4] = 40;
        send_pkt(5, 1'b0);
        idle_inputs();
        repeat (7) @(negedge clk_i);
        check("abort pre val", val_o, 1);
        srst_i = 1'b0;
        #1;
        check("abort val", val_o, 0);
        check("abort busy", busy_o, 0);
        check("abort data", data_o, 0);
        check("abort sop", sop_o, 0);
        check("abort eop", eop_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        srst_i = 1'b1;
        @(negedge clk_i);
        check("abort rel busy", busy_o, 0);
        check("abort rel val", val_o, 0);
        pkt[0] = 6; pkt[1] = 255; pkt[2] = 0; pkt[3] = 6;
        do_pkt("post_abort", 4, 1'b0);

        // Random back-to-back packets
        for (int p = 0; p < 200; p++) begin
            n = $urandom_range(3, 8);
            for (int i = 0; i < n; i++) begin
                pkt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3)
                                                     : $urandom_range(0, 255);
            end
            do_pkt($sformatf("rnd%0d", p), n, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
